// File: rtl/divisor_frec_prog.sv
// Programmable multi-channel clock divider: per-channel period/high time loaded over a
// valid/ready port, swapped in glitch-free at the next period boundary.

module divisor_frec_prog_ch #(
   parameter int CNT_W   = 26,
   parameter int DEF_DIV = 2
) (
   input  logic             clk_intput,
   input  logic             rst_n,
   input  logic             en,
   input  logic             ld,
   input  logic [CNT_W-1:0] ld_div,
   input  logic [CNT_W-1:0] ld_high,
   output logic             pending,
   output logic             clk_out,
   output logic             tick
);
   localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_DIV / 2);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d, div_a_q, div_a_d, high_a_q, high_a_d;
   logic [CNT_W-1:0] div_s_q, div_s_d, high_s_q, high_s_d, pos;
   logic             run_q, run_d, pending_q, pending_d;
   logic             clk_out_q, clk_out_d, tick_q, tick_d;

   // cnt_q is the position of the cycle currently shown on clk_out/tick; run_q tells
   // whether that position is live or the channel is just coming out of idle.
   always_comb begin
      cnt_d     = cnt_q;
      run_d     = run_q;
      div_a_d   = div_a_q;
      high_a_d  = high_a_q;
      div_s_d   = div_s_q;
      high_s_d  = high_s_q;
      pending_d = pending_q;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      pos       = '0;
      if (!en) begin
         cnt_d = '0;
         run_d = 1'b0;
         if (pending_q) begin
            div_a_d   = div_s_q;
            high_a_d  = high_s_q;
            pending_d = 1'b0;
         end
      end else begin
         run_d = 1'b1;
         if (run_q && (cnt_q < div_a_q - ONE)) begin
            pos = cnt_q + ONE;
         end else if (run_q && pending_q) begin
            div_a_d   = div_s_q;
            high_a_d  = high_s_q;
            pending_d = 1'b0;
         end
         cnt_d     = pos;
         clk_out_d = (pos < high_a_d);
         tick_d    = (pos == '0);
      end
      // An idle channel takes new settings straight away, so pending never shows there.
      if (ld) begin
         div_s_d  = ld_div;
         high_s_d = ld_high;
         if (en) begin
            pending_d = 1'b1;
         end else begin
            div_a_d  = ld_div;
            high_a_d = ld_high;
         end
      end
   end

   always_ff @(posedge clk_intput) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         run_q     <= 1'b0;
         div_a_q   <= DEF_D;
         high_a_q  <= DEF_H;
         div_s_q   <= DEF_D;
         high_s_q  <= DEF_H;
         pending_q <= 1'b0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         run_q     <= run_d;
         div_a_q   <= div_a_d;
         high_a_q  <= high_a_d;
         div_s_q   <= div_s_d;
         high_s_q  <= high_s_d;
         pending_q <= pending_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign pending = pending_q;
   assign clk_out = clk_out_q;
   assign tick    = tick_q;
endmodule

module divisor_frec_prog #(
   parameter int N_CH    = 4,
   parameter int CNT_W   = 26,
   parameter int DEF_DIV = 2,
   parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk_intput,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_high,
   output logic             cfg_err,
   output logic [N_CH-1:0]  clk_out,
   output logic [N_CH-1:0]  tick
);
   logic [N_CH-1:0] pend, ld;
   logic            ch_ok, pend_sel, accept, bad, cfg_err_q, cfg_err_d;

   always_comb begin
      pend_sel = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (cfg_ch == CH_W'(i)) pend_sel = pend[i];
      end
      ch_ok     = ({1'b0, cfg_ch} < (CH_W + 1)'(N_CH));
      cfg_ready = rst_n & ~(ch_ok & pend_sel);
      accept    = cfg_valid & cfg_ready;
      bad       = (cfg_div < CNT_W'(2)) | ~ch_ok;
      cfg_err_d = accept & bad;
   end

   always_ff @(posedge clk_intput) begin
      if (!rst_n) cfg_err_q <= 1'b0;
      else        cfg_err_q <= cfg_err_d;
   end

   assign cfg_err = cfg_err_q;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ld[gi] = accept & ~bad & (cfg_ch == CH_W'(gi));
      divisor_frec_prog_ch #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
         .clk_intput (clk_intput),
         .rst_n      (rst_n),
         .en         (en[gi]),
         .ld         (ld[gi]),
         .ld_div     (cfg_div),
         .ld_high    (cfg_high),
         .pending    (pend[gi]),
         .clk_out    (clk_out[gi]),
         .tick       (tick[gi])
      );
   end
endmodule

// File: tb/tb_divisor_frec_prog.sv
// Directed bench for divisor_frec_prog: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.

module tb_divisor_frec_prog;
   localparam int N_CH = 4, CNT_W = 26, CH_W = 3;

   typedef struct {
      logic [3:0] clk;
      logic [3:0] tick;
      logic       err;
      logic       rdy;
      bit         chk_rdy;
      string      nm;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n, cfg_valid, cfg_ready, cfg_err;
   logic [N_CH-1:0]  en, clk_out, tick;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div, cfg_high;

   exp_t sb[$];
   exp_t m;
   int   n_cmp = 0, n_bad = 0;
   int   ediv[4], ehigh[4], eph[4];
   logic [3:0] eon;

   always #5 clk = ~clk;

   divisor_frec_prog #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(2), .CH_W(CH_W)) dut (
      .clk_intput (clk),
      .rst_n      (rst_n),
      .en         (en),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_div    (cfg_div),
      .cfg_high   (cfg_high),
      .cfg_err    (cfg_err),
      .clk_out    (clk_out),
      .tick       (tick)
   );

   // One edge; expected outputs come from the hand-set period/high/phase per channel.
   // The ready expectation refers to the inputs the caller sets right after the step.
   task automatic step(input string nm, input bit ck_rdy, input bit rdy_v, input bit err_v);
      exp_t e;
      int   r;
      @(posedge clk);
      #1;
      e.clk = '0; e.tick = '0;
      for (int i = 0; i < 4; i++) begin
         if (eon[i]) begin
            r         = eph[i] % ediv[i];
            e.clk[i]  = (r < ehigh[i]);
            e.tick[i] = (r == 0);
            eph[i]++;
         end
      end
      e.err = err_v; e.rdy = rdy_v; e.chk_rdy = ck_rdy; e.nm = nm;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         m = sb.pop_front();
         n_cmp++;
         if (clk_out !== m.clk) begin
            n_bad++;
            $display("FAIL %s clk_out got %b want %b", m.nm, clk_out, m.clk);
         end
         n_cmp++;
         if (tick !== m.tick) begin
            n_bad++;
            $display("FAIL %s tick got %b want %b", m.nm, tick, m.tick);
         end
         n_cmp++;
         if (cfg_err !== m.err) begin
            n_bad++;
            $display("FAIL %s cfg_err got %b want %b", m.nm, cfg_err, m.err);
         end
         if (m.chk_rdy) begin
            n_cmp++;
            if (cfg_ready !== m.rdy) begin
               n_bad++;
               $display("FAIL %s cfg_ready got %b want %b", m.nm, cfg_ready, m.rdy);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;
      eon = '0;
      for (int i = 0; i < 4; i++) begin ediv[i] = 2; ehigh[i] = 1; eph[i] = 0; end

      // reset, then ch0 on defaults: 1,0,1,0 with tick every 2
      step("rst", 1, 0, 0);
      step("rst", 1, 1, 0);
      rst_n = 1'b1; en = 4'b0001; eon[0] = 1'b1; eph[0] = 0;
      repeat (8) step("def_ch0", 1, 1, 0);

      // ch1 on defaults, then reload to div=5 high=2 mid-period
      en = 4'b0011; eon[1] = 1'b1; eph[1] = 0;
      step("ch1_start", 1, 1, 0);
      cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 26'd5; cfg_high = 26'd2;
      step("ch1_old_tail", 1, 0, 0);
      cfg_valid = 1'b0;
      ediv[1] = 5; ehigh[1] = 2; eph[1] = 0;
      repeat (10) step("ch1_new", 1, 1, 0);

      // rejects: div<2, then channel out of range
      cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 26'd1; cfg_high = 26'd0;
      step("rej_div", 1, 1, 1);
      cfg_ch = 3'd7; cfg_div = 26'd5; cfg_high = 26'd1;
      step("rej_ch", 1, 1, 1);
      cfg_valid = 1'b0; cfg_ch = 3'd0;
      repeat (4) step("after_rej", 1, 1, 0);

      // ch2 idle load div=4 high=0, run, then high=9 accepted on a wrap edge
      cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 26'd4; cfg_high = 26'd0;
      step("ch2_idle_cfg", 1, 1, 0);
      cfg_valid = 1'b0; en = 4'b0111;
      eon[2] = 1'b1; ediv[2] = 4; ehigh[2] = 0; eph[2] = 0;
      repeat (8) step("ch2_low", 1, 1, 0);
      cfg_valid = 1'b1; cfg_high = 26'd9;
      step("ch2_acc_wrap", 1, 0, 0);
      cfg_valid = 1'b0;
      repeat (3) step("ch2_pend", 1, 0, 0);
      ehigh[2] = 9; eph[2] = 0;
      repeat (8) step("ch2_high", 1, 1, 0);

      // ch0 to div=6 high=3 while idle, drop en at cnt=3, re-enable after 5 cycles
      en = 4'b0110; eon[0] = 1'b0;
      cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 26'd6; cfg_high = 26'd3;
      step("ch0_idle_cfg", 1, 1, 0);
      cfg_valid = 1'b0; en = 4'b0111;
      eon[0] = 1'b1; ediv[0] = 6; ehigh[0] = 3; eph[0] = 0;
      repeat (4) step("ch0_run6", 1, 1, 0);
      en = 4'b0110; eon[0] = 1'b0;
      repeat (5) step("ch0_off", 1, 1, 0);
      en = 4'b0111; eon[0] = 1'b1; eph[0] = 0;
      repeat (8) step("ch0_restart", 1, 1, 0);

      // reset with a transfer pending on ch1: shadow discarded, defaults back
      cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 26'd3; cfg_high = 26'd1;
      step("ch1_acc_pre_rst", 1, 0, 0);
      cfg_valid = 1'b0; rst_n = 1'b0; eon = '0;
      step("rst_mid", 1, 1, 0);
      rst_n = 1'b1; eon = 4'b0111;
      for (int i = 0; i < 4; i++) begin ediv[i] = 2; ehigh[i] = 1; eph[i] = 0; end
      repeat (8) step("post_rst_def", 1, 1, 0);

      @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain got %0d entries left want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
